// File: rtl/snd_cmd_if.sv
// Sound command interface between the 68k and the sound Z80: fractional Z80
// clock enable, one-deep command latch with overrun flag, and SNDON interrupt.
module snd_cmd_if #(
  parameter int unsigned CE_INC = 179,
  parameter int unsigned CE_MOD = 2400
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic       snddt_n,
  input  logic [7:0] cpu_din,
  input  logic       sndon,
  output logic       z80_ce,
  input  logic       z80_m1_n,
  input  logic       z80_iorq_n,
  input  logic       z80_latch_rd_n,
  output logic [7:0] z80_cmd,
  output logic       z80_int_n,
  output logic       cmd_full,
  output logic       cmd_ovf
);

  localparam int unsigned ACC_W = $clog2(CE_MOD + CE_INC);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Fractional clock-enable divider
  logic [ACC_W-1:0] r_acc;
  logic             r_ce;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_sub;
  logic             w_wrap;

  always_comb begin
    w_sum  = {1'b0, r_acc} + CE_INC[ACC_W:0];
    w_sub  = w_sum - CE_MOD[ACC_W:0];
    w_wrap = (w_sum >= CE_MOD[ACC_W:0]);
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= w_wrap;
      r_acc <= w_wrap ? w_sub[ACC_W-1:0] : w_sum[ACC_W-1:0];
    end
  end

  // Command latch: the falling edge of snddt_n is registered into r_cap, and the
  // data sampled alongside it is loaded one edge later.
  logic       r_snd_prev;
  logic       r_cap;
  logic [7:0] r_din;
  logic [7:0] r_cmd;
  logic       r_full;
  logic       r_ovf;
  logic       r_rd_prev;
  logic       w_rd_fall;

  assign w_rd_fall = r_ce & r_rd_prev & ~z80_latch_rd_n;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_snd_prev <= 1'b1;
      r_cap      <= 1'b0;
      r_din      <= '0;
      r_cmd      <= '0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_prev  <= 1'b1;
    end else begin
      r_snd_prev <= snddt_n;
      r_cap      <= r_snd_prev & ~snddt_n;
      r_din      <= cpu_din;
      if (r_ce) r_rd_prev <= z80_latch_rd_n;
      // A capture takes priority over a simultaneous Z80 read
      if (r_cap) begin
        r_cmd  <= r_din;
        r_full <= 1'b1;
        if (r_full) r_ovf <= 1'b1;
      end else if (w_rd_fall) begin
        r_full <= 1'b0;
      end
    end
  end

  // SNDON interrupt request
  state_t r_state;
  state_t w_state_nxt;
  logic   r_son_prev;
  logic   w_son_rise;
  logic   w_ack;

  assign w_son_rise = sndon & ~r_son_prev;
  assign w_ack      = r_ce & ~z80_m1_n & ~z80_iorq_n;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_son_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_son_prev <= sndon;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_son_rise) w_state_nxt = PEND;
      PEND: if (w_ack && !w_son_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign z80_ce    = r_ce;
  assign z80_cmd   = r_cmd;
  assign cmd_full  = r_full;
  assign cmd_ovf   = r_ovf;
  assign z80_int_n = (r_state != PEND);

endmodule

// File: tb/tb_snd_cmd_if.sv
// Bench for snd_cmd_if: event-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_snd_cmd_if;

  localparam int unsigned INC = 179;
  localparam int unsigned MOD = 2400;

  logic       clk_main = 1'b0;
  logic       reset = 1'b1;
  logic       snddt_n = 1'b1;
  logic [7:0] cpu_din = 8'h00;
  logic       sndon = 1'b0;
  logic       z80_m1_n = 1'b1;
  logic       z80_iorq_n = 1'b1;
  logic       z80_latch_rd_n = 1'b1;
  logic       z80_ce;
  logic [7:0] z80_cmd;
  logic       z80_int_n;
  logic       cmd_full;
  logic       cmd_ovf;

  snd_cmd_if #(.CE_INC(INC), .CE_MOD(MOD)) dut (
    .clk_main       (clk_main),
    .reset          (reset),
    .snddt_n        (snddt_n),
    .cpu_din        (cpu_din),
    .sndon          (sndon),
    .z80_ce         (z80_ce),
    .z80_m1_n       (z80_m1_n),
    .z80_iorq_n     (z80_iorq_n),
    .z80_latch_rd_n (z80_latch_rd_n),
    .z80_cmd        (z80_cmd),
    .z80_int_n      (z80_int_n),
    .cmd_full       (cmd_full),
    .cmd_ovf        (cmd_ovf)
  );

  always #5 clk_main = ~clk_main;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Enable fires on edge n exactly when floor(n*INC/MOD) steps up.
  function automatic bit ce_at(input longint n);
    if (n < 1) return 1'b0;
    return ((n * INC) / MOD) != (((n - 1) * INC) / MOD);
  endfunction

  // Reference model, advanced at each clock edge from the sampled inputs.
  longint     m_n;
  bit         m_ce, m_full, m_ovf, m_pend;
  bit         m_son_last, m_rd_last, m_snd_last, m_cap_pend;
  logic [7:0] m_cmd, m_cap_data;
  bit         t_ce, t_rise, t_ack, t_rdfall;

  always @(posedge clk_main or posedge reset) begin
    if (reset) begin
      m_n = 0; m_ce = 0; m_full = 0; m_ovf = 0; m_pend = 0;
      m_son_last = 0; m_rd_last = 1; m_snd_last = 1; m_cap_pend = 0;
      m_cmd = 8'h00; m_cap_data = 8'h00;
    end else begin
      t_ce   = m_ce;
      t_rise = sndon && !m_son_last;
      m_son_last = sndon;
      t_ack  = t_ce && !z80_m1_n && !z80_iorq_n;
      m_pend = t_rise || (m_pend && !t_ack);
      t_rdfall = t_ce && m_rd_last && !z80_latch_rd_n;
      if (t_ce) m_rd_last = z80_latch_rd_n;
      if (m_cap_pend) begin
        if (m_full) m_ovf = 1;
        m_full = 1;
        m_cmd  = m_cap_data;
      end else if (t_rdfall) begin
        m_full = 0;
      end
      m_cap_pend = m_snd_last && !snddt_n;
      m_cap_data = cpu_din;
      m_snd_last = snddt_n;
      m_n++;
      m_ce = ce_at(m_n);
    end
  end

  always @(negedge clk_main) begin
    check("ce", {31'b0, z80_ce}, {31'b0, m_ce});
    check("cmd", {24'b0, z80_cmd}, {24'b0, m_cmd});
    check("full", {31'b0, cmd_full}, {31'b0, m_full});
    check("ovf", {31'b0, cmd_ovf}, {31'b0, m_ovf});
    check("int_n", {31'b0, z80_int_n}, {31'b0, !m_pend});
  end

  task automatic do_write(input logic [7:0] d);
    @(negedge clk_main); #1 snddt_n = 1'b0; cpu_din = d;
    repeat (4) @(negedge clk_main);
    #1 snddt_n = 1'b1;
    repeat (3) @(negedge clk_main);
  endtask

  task automatic do_read();
    @(negedge clk_main); #1 z80_latch_rd_n = 1'b0;
    repeat (30) @(negedge clk_main);
    #1 z80_latch_rd_n = 1'b1;
    repeat (30) @(negedge clk_main);
  endtask

  // Waits (bounded) for a negedge on which z80_ce is visible.
  task automatic wait_ce(input string name);
    int k = 0;
    do begin
      @(negedge clk_main);
      k++;
    end while (!z80_ce && k < 40);
    if (!z80_ce) check(name, 32'd0, 32'd1);
  endtask

  task automatic do_ack();
    @(negedge clk_main); #1 z80_m1_n = 1'b0; z80_iorq_n = 1'b0;
    wait_ce("ack_wait_timeout");
    @(negedge clk_main);
    check("ack_clear", {31'b0, z80_int_n}, 32'd1);
    #1 z80_m1_n = 1'b1; z80_iorq_n = 1'b1;
  endtask

  int cnt, adj;
  bit prev_ce;

  initial begin
    repeat (3) @(negedge clk_main);
    check("rst_cmd", {24'b0, z80_cmd}, 32'h00);
    check("rst_full", {31'b0, cmd_full}, 32'd0);
    check("rst_ovf", {31'b0, cmd_ovf}, 32'd0);
    check("rst_int_n", {31'b0, z80_int_n}, 32'd1);
    check("rst_ce", {31'b0, z80_ce}, 32'd0);
    #1 reset = 1'b0;

    // Clock enable density over two full modulus periods
    cnt = 0; adj = 0; prev_ce = 0;
    repeat (4800) begin
      @(negedge clk_main);
      if (z80_ce) begin
        cnt++;
        if (prev_ce) adj++;
      end
      prev_ce = z80_ce;
    end
    check("ce_count", cnt, 32'd358);
    check("ce_adjacent", adj, 32'd0);

    // Single write, latency and single capture
    @(negedge clk_main); #1 snddt_n = 1'b0; cpu_din = 8'h5A;
    @(negedge clk_main);
    check("wr_lat1_full", {31'b0, cmd_full}, 32'd0);
    @(negedge clk_main);
    check("wr_cmd", {24'b0, z80_cmd}, 32'h5A);
    check("wr_full", {31'b0, cmd_full}, 32'd1);
    repeat (4) @(negedge clk_main);
    #1 snddt_n = 1'b1;
    @(negedge clk_main);
    check("wr_once_ovf", {31'b0, cmd_ovf}, 32'd0);
    do_read();
    check("rd_full", {31'b0, cmd_full}, 32'd0);
    check("rd_cmd_kept", {24'b0, z80_cmd}, 32'h5A);

    // Overrun
    do_write(8'h11);
    do_write(8'h22);
    check("ovr_cmd", {24'b0, z80_cmd}, 32'h22);
    check("ovr_ovf", {31'b0, cmd_ovf}, 32'd1);
    do_read();
    check("ovr_rd_full", {31'b0, cmd_full}, 32'd0);
    check("ovr_sticky", {31'b0, cmd_ovf}, 32'd1);

    // Interrupt request, acknowledge, no re-request on held level
    @(negedge clk_main); #1 sndon = 1'b1;
    repeat (2) @(negedge clk_main);
    check("int_req", {31'b0, z80_int_n}, 32'd0);
    do_ack();
    repeat (40) @(negedge clk_main);
    check("no_rereq", {31'b0, z80_int_n}, 32'd1);

    // New sndon edge on the same cycle as the acknowledge
    @(negedge clk_main); #1 sndon = 1'b0;
    @(negedge clk_main); #1 sndon = 1'b1;
    @(negedge clk_main); #1 sndon = 1'b0;
    repeat (2) @(negedge clk_main);
    check("pend_again", {31'b0, z80_int_n}, 32'd0);
    begin
      int k = 0;
      while (z80_ce && k < 5) begin @(negedge clk_main); k++; end
    end
    #1 z80_m1_n = 1'b0; z80_iorq_n = 1'b0;
    wait_ce("coinc_wait_timeout");
    #1 sndon = 1'b1;
    @(negedge clk_main);
    check("coinc_stay_pend", {31'b0, z80_int_n}, 32'd0);
    #1 z80_m1_n = 1'b1; z80_iorq_n = 1'b1;
    repeat (20) @(negedge clk_main);
    check("coinc_still_pend", {31'b0, z80_int_n}, 32'd0);
    do_ack();

    // Capture landing on the same edge as a Z80 read
    do_write(8'h33);
    begin
      int k = 0;
      while (!ce_at(m_n + 1) && k < 40) begin @(negedge clk_main); k++; end
    end
    #1 snddt_n = 1'b0; cpu_din = 8'h44; z80_latch_rd_n = 1'b0;
    repeat (2) @(negedge clk_main);
    check("coinc_full", {31'b0, cmd_full}, 32'd1);
    check("coinc_cmd", {24'b0, z80_cmd}, 32'h44);
    #1 snddt_n = 1'b1;
    repeat (30) @(negedge clk_main);
    #1 z80_latch_rd_n = 1'b1;
    repeat (30) @(negedge clk_main);
    check("coinc_no_extra_rd", {31'b0, cmd_full}, 32'd1);

    // Asynchronous reset while PEND with a full latch
    @(negedge clk_main); #1 sndon = 1'b0;
    @(negedge clk_main); #1 sndon = 1'b1;
    repeat (2) @(negedge clk_main);
    check("pre_rst_int_n", {31'b0, z80_int_n}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_int_n", {31'b0, z80_int_n}, 32'd1);
    check("arst_full", {31'b0, cmd_full}, 32'd0);
    check("arst_cmd", {24'b0, z80_cmd}, 32'h00);
    check("arst_ovf", {31'b0, cmd_ovf}, 32'd0);
    @(negedge clk_main); #1 reset = 1'b0;
    repeat (2) @(negedge clk_main);
    check("rel_edge_int", {31'b0, z80_int_n}, 32'd0);
    do_ack();

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk_main); #1;
      if ($urandom_range(0, 7) == 0) snddt_n = ~snddt_n;
      if ($urandom_range(0, 19) == 0) z80_latch_rd_n = ~z80_latch_rd_n;
      if ($urandom_range(0, 15) == 0) sndon = ~sndon;
      z80_m1_n   = ($urandom_range(0, 2) != 0);
      z80_iorq_n = ($urandom_range(0, 2) != 0);
      cpu_din    = 8'($urandom);
    end
    @(negedge clk_main); #1;
    snddt_n = 1'b1; z80_latch_rd_n = 1'b1; z80_m1_n = 1'b1; z80_iorq_n = 1'b1;
    repeat (10) @(negedge clk_main);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
